// File: rtl/rep_str_seq_if.sv
// ============================================================================
// Module      : rep_str_seq_if
// Description : Memory request/acknowledge bus between the string sequencer
//               and the execute-stage memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rep_str_seq_if;
    logic mem_req;
    logic mem_we;
    logic mem_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_sel,
        output mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/rep_str_seq.sv
// ============================================================================
// Module      : rep_str_seq
// Description : Execute-stage sequencer for MOVS/STOS/CMPS/SCAS with optional
//               REP/REPE/REPNE prefix; stalls the pipeline while busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rep_str_seq (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start,
    input  wire logic        abort,
    input  wire logic [1:0]  str_op,
    input  wire logic [1:0]  rep_mode,
    input  wire logic [1:0]  op_size,
    input  wire logic [31:0] ecx_in,
    input  wire logic        cmp_zf,
    rep_str_seq_if.master    mem_bus,
    output logic [3:0]       alu1_op,
    output logic [1:0]       ptr_sel,
    output logic             ptr_we,
    output logic [31:0]      ecx_out,
    output logic             ecx_we,
    output logic             flags_we,
    output logic [1:0]       opsize_out,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RD_SRC = 4'd1;
    localparam logic [3:0] S_RD_DST = 4'd2;
    localparam logic [3:0] S_WR_DST = 4'd3;
    localparam logic [3:0] S_UPD_SI = 4'd4;
    localparam logic [3:0] S_UPD_DI = 4'd5;
    localparam logic [3:0] S_UPD_CX = 4'd6;
    localparam logic [3:0] S_TEST   = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    localparam logic [1:0] c_OP_MOVS = 2'd0;
    localparam logic [1:0] c_OP_STOS = 2'd1;
    localparam logic [1:0] c_OP_CMPS = 2'd2;
    localparam logic [1:0] c_OP_SCAS = 2'd3;

    localparam logic [1:0] c_REP_E  = 2'd1;
    localparam logic [1:0] c_REP_NE = 2'd2;

    localparam logic [3:0] c_ALU_PTR  = 4'hA;
    localparam logic [3:0] c_ALU_PASS = 4'h4;

    localparam logic [1:0] c_SEL_ESI = 2'd0;
    localparam logic [1:0] c_SEL_EDI = 2'd1;
    localparam logic [1:0] c_SEL_ECX = 2'd2;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [31:0] r_cnt;
    logic        r_zf;
    logic [1:0]  r_op;
    logic [1:0]  r_rep;
    logic [1:0]  r_size;

    logic        w_start_rep;
    logic        w_rep;
    logic        w_is_cmp;
    logic        w_accept;

    // Entry state of one iteration for a given string op.
    function automatic logic [3:0] first_state(input logic [1:0] op);
        case (op)
            c_OP_STOS: first_state = S_WR_DST;
            c_OP_SCAS: first_state = S_RD_DST;
            default:   first_state = S_RD_SRC;
        endcase
    endfunction

    assign w_start_rep = (rep_mode == c_REP_E) || (rep_mode == c_REP_NE);
    assign w_rep       = (r_rep == c_REP_E) || (r_rep == c_REP_NE);
    assign w_is_cmp    = (r_op == c_OP_CMPS) || (r_op == c_OP_SCAS);
    assign w_accept    = (r_state == S_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 32'd0;
            r_zf   <= 1'b0;
            r_op   <= 2'd0;
            r_rep  <= 2'd0;
            r_size <= 2'd0;
        end else begin
            if (w_accept) begin
                r_cnt  <= ecx_in;
                r_op   <= str_op;
                r_rep  <= rep_mode;
                r_size <= op_size;
            end else if (r_state == S_UPD_CX) begin
                r_cnt <= r_cnt - 32'd1;
            end
            if ((r_state == S_RD_DST) && mem_bus.mem_ack && w_is_cmp) begin
                r_zf <= cmp_zf;
            end
        end
    end

    // Next state plus Moore output decode from the state register.
    always_comb begin
        w_next           = r_state;
        mem_bus.mem_req  = 1'b0;
        mem_bus.mem_we   = 1'b0;
        mem_bus.mem_sel  = 1'b0;
        alu1_op          = c_ALU_PASS;
        ptr_sel          = c_SEL_ESI;
        ptr_we           = 1'b0;
        ecx_out          = 32'd0;
        ecx_we           = 1'b0;
        flags_we         = 1'b0;
        busy             = (r_state != S_IDLE);
        done             = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_start_rep && (ecx_in == 32'd0)) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = first_state(str_op);
                    end
                end
            end
            S_RD_SRC: begin
                mem_bus.mem_req = 1'b1;
                if (mem_bus.mem_ack) begin
                    w_next = (r_op == c_OP_CMPS) ? S_RD_DST : S_WR_DST;
                end
            end
            S_RD_DST: begin
                mem_bus.mem_req = 1'b1;
                mem_bus.mem_sel = 1'b1;
                flags_we        = w_is_cmp;
                if (mem_bus.mem_ack) begin
                    w_next = (r_op == c_OP_CMPS) ? S_UPD_SI : S_UPD_DI;
                end
            end
            S_WR_DST: begin
                mem_bus.mem_req = 1'b1;
                mem_bus.mem_we  = 1'b1;
                mem_bus.mem_sel = 1'b1;
                if (mem_bus.mem_ack) begin
                    w_next = (r_op == c_OP_MOVS) ? S_UPD_SI : S_UPD_DI;
                end
            end
            S_UPD_SI: begin
                alu1_op = c_ALU_PTR;
                ptr_sel = c_SEL_ESI;
                ptr_we  = 1'b1;
                w_next  = S_UPD_DI;
            end
            S_UPD_DI: begin
                alu1_op = c_ALU_PTR;
                ptr_sel = c_SEL_EDI;
                ptr_we  = 1'b1;
                w_next  = w_rep ? S_UPD_CX : S_DONE;
            end
            S_UPD_CX: begin
                ptr_sel = c_SEL_ECX;
                ecx_out = r_cnt - 32'd1;
                ecx_we  = 1'b1;
                w_next  = S_TEST;
            end
            S_TEST: begin
                // REPE/REPNE differ only for the compare ops; MOVS/STOS ignore ZF.
                if (r_cnt == 32'd0) begin
                    w_next = S_DONE;
                end else if (w_is_cmp && (r_rep == c_REP_E) && !r_zf) begin
                    w_next = S_DONE;
                end else if (w_is_cmp && (r_rep == c_REP_NE) && r_zf) begin
                    w_next = S_DONE;
                end else begin
                    w_next = first_state(r_op);
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (abort) begin
            w_next = S_IDLE;
        end
    end

    assign opsize_out = r_size;

endmodule

`default_nettype wire

// File: tb/tb_rep_str_seq.sv
// ============================================================================
// Module      : tb_rep_str_seq
// Description : Scoreboard bench for rep_str_seq; expected bus, pointer, ECX,
//               flag and done events are queued up front and matched in order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rep_str_seq;

    localparam logic [3:0] c_EV_MEM  = 4'd1;
    localparam logic [3:0] c_EV_PTR  = 4'd2;
    localparam logic [3:0] c_EV_ECX  = 4'd3;
    localparam logic [3:0] c_EV_FLG  = 4'd4;
    localparam logic [3:0] c_EV_DONE = 4'd5;
    localparam logic [47:0] c_RESET_OUTS = {3'b000, 4'h4, 2'b00, 1'b0, 32'd0,
                                            1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  str_op = 2'd0;
    logic [1:0]  rep_mode = 2'd0;
    logic [1:0]  op_size = 2'd0;
    logic [31:0] ecx_in = 32'd0;
    logic        cmp_zf = 1'b0;
    logic [3:0]  alu1_op;
    logic [1:0]  ptr_sel;
    logic        ptr_we;
    logic [31:0] ecx_out;
    logic        ecx_we;
    logic        flags_we;
    logic [1:0]  opsize_out;
    logic        busy;
    logic        done;

    rep_str_seq_if bus ();

    rep_str_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .str_op     (str_op),
        .rep_mode   (rep_mode),
        .op_size    (op_size),
        .ecx_in     (ecx_in),
        .cmp_zf     (cmp_zf),
        .mem_bus    (bus.master),
        .alu1_op    (alu1_op),
        .ptr_sel    (ptr_sel),
        .ptr_we     (ptr_we),
        .ecx_out    (ecx_out),
        .ecx_we     (ecx_we),
        .flags_we   (flags_we),
        .opsize_out (opsize_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [47:0] w_outs;
    assign w_outs = {bus.mem_req, bus.mem_we, bus.mem_sel, alu1_op, ptr_sel, ptr_we,
                     ecx_out, ecx_we, flags_we, opsize_out, busy, done};

    int          n_checks = 0;
    int          n_fail = 0;
    logic [39:0] exp_q[$];
    logic [39:0] obs_q[$];
    logic [39:0] r_obs;
    logic [39:0] r_exp;
    bit          zf_list[$];
    bit          sb_en = 1'b0;
    bit          ack_tied = 1'b0;
    int          ack_delay = 0;
    int          wcnt = 0;

    // Memory model drives ack first, then the monitor logs this cycle's events.
    always @(negedge clk) begin
        if (ack_tied) begin
            bus.mem_ack = 1'b1;
        end else if (bus.mem_req && !bus.mem_ack) begin
            if (wcnt >= ack_delay) begin
                bus.mem_ack = 1'b1;
                wcnt = 0;
            end else begin
                wcnt = wcnt + 1;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end
        if (bus.mem_ack && bus.mem_req && bus.mem_sel && !bus.mem_we) begin
            cmp_zf = (zf_list.size() > 0) ? zf_list.pop_front() : 1'b0;
        end

        if (rst_n && sb_en) begin
            if (bus.mem_req && bus.mem_ack)
                obs_q.push_back({c_EV_MEM, 4'd0, 30'd0, bus.mem_we, bus.mem_sel});
            if (flags_we && bus.mem_ack)
                obs_q.push_back({c_EV_FLG, 36'd0});
            if (ptr_we)
                obs_q.push_back({c_EV_PTR, alu1_op, 30'd0, ptr_sel});
            if (ecx_we)
                obs_q.push_back({c_EV_ECX, 2'b00, ptr_sel, ecx_out});
            if (done)
                obs_q.push_back({c_EV_DONE, 36'd0});
            while (obs_q.size() > 0) begin
                r_obs = obs_q.pop_front();
                n_checks = n_checks + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL sb_unexpected: got event %h, required no event", r_obs);
                end else begin
                    r_exp = exp_q.pop_front();
                    if (r_obs !== r_exp) begin
                        n_fail = n_fail + 1;
                        $display("FAIL sb_event: got %h, required %h", r_obs, r_exp);
                    end
                end
            end
        end
    end

    task automatic launch(input logic [1:0] op, input logic [1:0] rep,
                          input logic [1:0] sz, input logic [31:0] cnt);
        @(negedge clk);
        str_op   = op;
        rep_mode = rep;
        op_size  = sz;
        ecx_in   = cnt;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit ok);
        cyc = 1;
        ok  = 1'b0;
        while (cyc < budget) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc = cyc + 1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks = n_checks + 1;
        if (w_outs !== c_RESET_OUTS) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_outputs: got %h, required %h", w_outs, c_RESET_OUTS);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks = n_checks + 1;
        if (w_outs !== c_RESET_OUTS) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_idle: got %h, required %h", w_outs, c_RESET_OUTS);
        end
    endtask

    task automatic test_stos();
        int cyc;
        bit ok;
        ack_tied = 1'b1;
        sb_en = 1'b1;
        exp_q.push_back({c_EV_MEM, 4'd0, 30'd0, 2'b11});
        exp_q.push_back({c_EV_PTR, 4'hA, 30'd0, 2'd1});
        exp_q.push_back({c_EV_DONE, 36'd0});
        launch(2'd1, 2'd0, 2'd2, 32'd7);
        n_checks = n_checks + 1;
        if ({busy, opsize_out} !== 3'b110) begin
            n_fail = n_fail + 1;
            $display("FAIL stos_busy_size: got %b, required 110", {busy, opsize_out});
        end
        wait_done(20, cyc, ok);
        n_checks = n_checks + 1;
        if (!ok || cyc !== 3) begin
            n_fail = n_fail + 1;
            $display("FAIL stos_latency: got done=%0d at cycle %0d, required cycle 3", ok, cyc);
        end
        @(negedge clk);
        n_checks = n_checks + 1;
        if (exp_q.size() !== 0 || busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL stos_drain: got %0d pending busy=%b, required 0 pending busy=0",
                     exp_q.size(), busy);
        end
    endtask

    task automatic test_rep_movs();
        int cyc;
        bit ok;
        ack_tied = 1'b0;
        ack_delay = 2;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({c_EV_MEM, 4'd0, 30'd0, 2'b00});
            exp_q.push_back({c_EV_MEM, 4'd0, 30'd0, 2'b11});
            exp_q.push_back({c_EV_PTR, 4'hA, 30'd0, 2'd0});
            exp_q.push_back({c_EV_PTR, 4'hA, 30'd0, 2'd1});
            exp_q.push_back({c_EV_ECX, 4'd2, 32'(2 - i)});
        end
        exp_q.push_back({c_EV_DONE, 36'd0});
        launch(2'd0, 2'd1, 2'd1, 32'd3);
        wait_done(300, cyc, ok);
        @(negedge clk);
        n_checks = n_checks + 1;
        if (!ok || exp_q.size() !== 0) begin
            n_fail = n_fail + 1;
            $display("FAIL rep_movs_complete: got done=%0d pending=%0d, required done=1 pending=0",
                     ok, exp_q.size());
        end
    endtask

    task automatic test_repe_cmps();
        int cyc;
        bit ok;
        ack_tied = 1'b1;
        zf_list = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({c_EV_MEM, 4'd0, 30'd0, 2'b00});
            exp_q.push_back({c_EV_MEM, 4'd0, 30'd0, 2'b01});
            exp_q.push_back({c_EV_FLG, 36'd0});
            exp_q.push_back({c_EV_PTR, 4'hA, 30'd0, 2'd0});
            exp_q.push_back({c_EV_PTR, 4'hA, 30'd0, 2'd1});
            exp_q.push_back({c_EV_ECX, 4'd2, 32'(4 - i)});
        end
        exp_q.push_back({c_EV_DONE, 36'd0});
        launch(2'd2, 2'd1, 2'd0, 32'd5);
        wait_done(300, cyc, ok);
        @(negedge clk);
        n_checks = n_checks + 1;
        if (!ok || exp_q.size() !== 0 || zf_list.size() !== 0) begin
            n_fail = n_fail + 1;
            $display("FAIL repe_cmps_stop: got done=%0d pending=%0d zf_left=%0d, required 1/0/0",
                     ok, exp_q.size(), zf_list.size());
        end
    endtask

    task automatic test_repne_scas();
        int cyc;
        bit ok;
        ack_tied = 1'b0;
        ack_delay = 1;
        zf_list = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({c_EV_MEM, 4'd0, 30'd0, 2'b01});
            exp_q.push_back({c_EV_FLG, 36'd0});
            exp_q.push_back({c_EV_PTR, 4'hA, 30'd0, 2'd1});
            exp_q.push_back({c_EV_ECX, 4'd2, 32'(3 - i)});
        end
        exp_q.push_back({c_EV_DONE, 36'd0});
        launch(2'd3, 2'd2, 2'd1, 32'd4);
        wait_done(300, cyc, ok);
        @(negedge clk);
        n_checks = n_checks + 1;
        if (!ok || exp_q.size() !== 0) begin
            n_fail = n_fail + 1;
            $display("FAIL repne_scas_stop: got done=%0d pending=%0d, required done=1 pending=0",
                     ok, exp_q.size());
        end
    endtask

    task automatic test_rep_zero();
        int cyc;
        bit ok;
        ack_tied = 1'b1;
        exp_q.push_back({c_EV_DONE, 36'd0});
        launch(2'd1, 2'd1, 2'd2, 32'd0);
        wait_done(20, cyc, ok);
        n_checks = n_checks + 1;
        if (!ok || cyc !== 1) begin
            n_fail = n_fail + 1;
            $display("FAIL rep_zero_latency: got done=%0d at cycle %0d, required cycle 1", ok, cyc);
        end
        @(negedge clk);
        n_checks = n_checks + 1;
        if (exp_q.size() !== 0 || busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL rep_zero_drain: got pending=%0d busy=%b, required 0/0",
                     exp_q.size(), busy);
        end
    endtask

    task automatic test_abort_busy();
        int  wr_cnt = 0;
        bit  hit = 1'b0;
        ack_tied = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({c_EV_MEM, 4'd0, 30'd0, 2'b00});
            exp_q.push_back({c_EV_MEM, 4'd0, 30'd0, 2'b11});
            if (i == 0) begin
                exp_q.push_back({c_EV_PTR, 4'hA, 30'd0, 2'd0});
                exp_q.push_back({c_EV_PTR, 4'hA, 30'd0, 2'd1});
                exp_q.push_back({c_EV_ECX, 4'd2, 32'd9});
            end
        end
        launch(2'd0, 2'd1, 2'd2, 32'd10);
        str_op   = 2'd1;
        rep_mode = 2'd0;
        op_size  = 2'd0;
        ecx_in   = 32'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks = n_checks + 1;
        if (opsize_out !== 2'd2 || busy !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL start_while_busy: got size=%0d busy=%b, required size=2 busy=1",
                     opsize_out, busy);
        end
        for (int i = 0; i < 60; i++) begin
            if (bus.mem_req && bus.mem_we) wr_cnt = wr_cnt + 1;
            if (wr_cnt == 2) begin
                abort = 1'b1;
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        abort = 1'b0;
        n_checks = n_checks + 1;
        if (!hit || busy !== 1'b0 || done !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_idle: got reached=%0d busy=%b done=%b, required 1/0/0",
                     hit, busy, done);
        end
        repeat (3) @(negedge clk);
        n_checks = n_checks + 1;
        if (exp_q.size() !== 0 || busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_drain: got pending=%0d busy=%b, required 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_async_reset();
        sb_en = 1'b0;
        ack_tied = 1'b1;
        launch(2'd1, 2'd1, 2'd2, 32'd100);
        repeat (5) @(negedge clk);
        n_checks = n_checks + 1;
        if (busy !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL async_pre_busy: got busy=%b, required 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks = n_checks + 1;
        if (w_outs !== c_RESET_OUTS) begin
            n_fail = n_fail + 1;
            $display("FAIL async_reset_outputs: got %h, required %h", w_outs, c_RESET_OUTS);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        sb_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok;
        ack_tied = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({c_EV_MEM, 4'd0, 30'd0, 2'b11});
            exp_q.push_back({c_EV_PTR, 4'hA, 30'd0, 2'd1});
            exp_q.push_back({c_EV_DONE, 36'd0});
            launch(2'd1, 2'd3, 2'(k), 32'd5);
            n_checks = n_checks + 1;
            if (opsize_out !== 2'(k)) begin
                n_fail = n_fail + 1;
                $display("FAIL b2b_size_%0d: got %0d, required %0d", k, opsize_out, k);
            end
            wait_done(20, cyc, ok);
            n_checks = n_checks + 1;
            if (!ok || cyc !== 3) begin
                n_fail = n_fail + 1;
                $display("FAIL b2b_latency_%0d: got done=%0d at cycle %0d, required cycle 3",
                         k, ok, cyc);
            end
        end
        @(negedge clk);
        n_checks = n_checks + 1;
        if (exp_q.size() !== 0) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_drain: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stos();
        test_rep_movs();
        test_repe_cmps();
        test_repne_scas();
        test_rep_zero();
        test_abort_busy();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
